// File: rtl/instr_fetch_if.sv
// Bundles the instruction-memory port, the issue handshake and the redirect
// input of the fetch front end. master = fetch unit, slave = memory/decoder side.
// Ports: mem_req/mem_addr/mem_ack/mem_rdata, issue_valid/issue_ready/opCode/instr/issue_pc, redirect_valid/redirect_pc.
interface instr_fetch_if #(
    parameter int PC_W = 16
);
    logic            mem_req;
    logic [PC_W-1:0] mem_addr;
    logic            mem_ack;
    logic [7:0]      mem_rdata;
    logic            issue_valid;
    logic            issue_ready;
    logic [3:0]      opCode;
    logic [15:0]     instr;
    logic [PC_W-1:0] issue_pc;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;

    modport master (
        output mem_req, mem_addr, issue_valid, opCode, instr, issue_pc,
        input  mem_ack, mem_rdata, issue_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, issue_valid, opCode, instr, issue_pc,
        output mem_ack, mem_rdata, issue_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetches a 16-bit big-endian instruction as two byte reads and issues it with its opCode and pc.
// Latency: 3 cycles per instruction with zero-wait memory and a ready decoder; all outputs registered.
// Backpressure: holds the issued instruction while issue_ready=0; memory requests are held until mem_ack.
// Ports: clk, rst_n (async active-low), bus (instr_fetch_if.master: memory port, issue handshake, redirect).
module instr_fetch #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_if.master      bus
);
    typedef enum logic [1:0] {FETCH_HI, FETCH_LO, ISSUE} state_t;

    localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(1));
    localparam logic [PC_W-1:0] PC_RST     = RESET_PC & ALIGN_MASK;

    state_t          r_state,       w_state;
    logic [PC_W-1:0] r_pc,          w_pc;
    logic            r_mem_req,     w_mem_req;
    logic [PC_W-1:0] r_mem_addr,    w_mem_addr;
    logic            r_issue_valid, w_issue_valid;
    logic [15:0]     r_instr,       w_instr;
    logic [3:0]      r_opcode,      w_opcode;
    logic [PC_W-1:0] r_issue_pc,    w_issue_pc;
    logic            r_redir_pend,  w_redir_pend;
    logic [PC_W-1:0] r_redir_tgt,   w_redir_tgt;

    logic            w_ack;
    logic [PC_W-1:0] w_redir_in;
    logic            w_have_tgt;
    logic [PC_W-1:0] w_tgt;

    always_comb begin
        w_state       = r_state;
        w_pc          = r_pc;
        w_mem_req     = r_mem_req;
        w_mem_addr    = r_mem_addr;
        w_issue_valid = r_issue_valid;
        w_instr       = r_instr;
        w_opcode      = r_opcode;
        w_issue_pc    = r_issue_pc;
        w_redir_pend  = r_redir_pend;
        w_redir_tgt   = r_redir_tgt;

        // A response only counts against a request we actually made.
        w_ack      = r_mem_req & bus.mem_ack;
        w_redir_in = bus.redirect_pc & ALIGN_MASK;
        // A redirect in this very cycle supersedes any older pending one.
        w_have_tgt = bus.redirect_valid | r_redir_pend;
        w_tgt      = bus.redirect_valid ? w_redir_in : r_redir_tgt;

        unique case (r_state)
            FETCH_HI, FETCH_LO: begin
                if (!r_mem_req) begin
                    // First cycle after reset: nothing outstanding, start fetching.
                    w_mem_req = 1'b1;
                    if (bus.redirect_valid) begin
                        w_pc       = w_redir_in;
                        w_mem_addr = w_redir_in;
                    end else begin
                        w_mem_addr = r_pc;
                    end
                end else if (w_ack) begin
                    if (w_have_tgt) begin
                        // Byte belongs to the abandoned path: drop it and restart at the target.
                        w_pc         = w_tgt;
                        w_mem_addr   = w_tgt;
                        w_redir_pend = 1'b0;
                        w_state      = FETCH_HI;
                    end else if (r_state == FETCH_HI) begin
                        w_instr[15:8] = bus.mem_rdata;
                        w_mem_addr    = r_pc + PC_W'(1);
                        w_state       = FETCH_LO;
                    end else begin
                        w_instr[7:0]  = bus.mem_rdata;
                        w_mem_req     = 1'b0;
                        w_issue_valid = 1'b1;
                        w_issue_pc    = r_pc;
                        w_opcode      = r_instr[15:12];
                        w_state       = ISSUE;
                    end
                end else if (bus.redirect_valid) begin
                    // Request in flight cannot be withdrawn; remember where to go.
                    w_redir_pend = 1'b1;
                    w_redir_tgt  = w_redir_in;
                end
            end
            ISSUE: begin
                if (bus.redirect_valid) begin
                    // Redirect wins over pc+2 even if the instruction is accepted now.
                    w_pc          = w_redir_in;
                    w_mem_addr    = w_redir_in;
                    w_mem_req     = 1'b1;
                    w_issue_valid = 1'b0;
                    w_state       = FETCH_HI;
                end else if (bus.issue_ready) begin
                    w_pc          = r_pc + PC_W'(2);
                    w_mem_addr    = r_pc + PC_W'(2);
                    w_mem_req     = 1'b1;
                    w_issue_valid = 1'b0;
                    w_state       = FETCH_HI;
                end
            end
            default: w_state = FETCH_HI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= FETCH_HI;
            r_pc          <= PC_RST;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= PC_RST;
            r_issue_valid <= 1'b0;
            r_instr       <= '0;
            r_opcode      <= '0;
            r_issue_pc    <= '0;
            r_redir_pend  <= 1'b0;
            r_redir_tgt   <= '0;
        end else begin
            r_state       <= w_state;
            r_pc          <= w_pc;
            r_mem_req     <= w_mem_req;
            r_mem_addr    <= w_mem_addr;
            r_issue_valid <= w_issue_valid;
            r_instr       <= w_instr;
            r_opcode      <= w_opcode;
            r_issue_pc    <= w_issue_pc;
            r_redir_pend  <= w_redir_pend;
            r_redir_tgt   <= w_redir_tgt;
        end
    end

    assign bus.mem_req     = r_mem_req;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.issue_valid = r_issue_valid;
    assign bus.instr       = r_instr;
    assign bus.opCode      = r_opcode;
    assign bus.issue_pc    = r_issue_pc;
endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        ready = 1'b0;
    logic        rv = 1'b0;
    logic [15:0] rpc = '0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic        m_ack;

    logic [7:0] mem [65536];

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ins;
    } exp_t;
    exp_t        exp_q[$];
    logic [15:0] log2[$];

    int n_tests = 0;
    int n_fail = 0;
    int n_issued = 0;

    instr_fetch_if #(.PC_W(16)) bus ();
    instr_fetch_if #(.PC_W(16)) bus2 ();

    instr_fetch #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master));
    instr_fetch #(.PC_W(16), .RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .bus(bus2.master));

    // Memory model: ack after ack_delay cycles of a held request.
    assign m_ack              = bus.mem_req && (wait_cnt >= ack_delay);
    assign bus.mem_ack        = m_ack;
    assign bus.mem_rdata      = mem[bus.mem_addr];
    assign bus.issue_ready    = ready;
    assign bus.redirect_valid = rv;
    assign bus.redirect_pc    = rpc;

    assign bus2.mem_ack        = bus2.mem_req;
    assign bus2.mem_rdata      = mem[bus2.mem_addr];
    assign bus2.issue_ready    = 1'b1;
    assign bus2.redirect_valid = 1'b0;
    assign bus2.redirect_pc    = '0;

    always @(posedge clk) begin
        if (bus.mem_req && !m_ack) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
    end

    function automatic logic [15:0] model_instr(input logic [15:0] pc);
        logic [15:0] pc1;
        pc1 = pc + 16'd1;
        return {mem[pc], mem[pc1]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted instruction is compared with the queued expectation.
    always @(negedge clk) begin
        if (rst_n && bus.issue_valid && ready) begin
            n_issued++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL sb_unexpected: observed issue pc %h expected no issue", bus.issue_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_instr", 32'(bus.instr), 32'(e.ins));
                check("sb_opcode", 32'(bus.opCode), 32'(e.ins[15:12]));
                check("sb_pc", 32'(bus.issue_pc), 32'(e.pc));
            end
        end
        if (rst_n && bus2.mem_req && bus2.mem_ack) log2.push_back(bus2.mem_addr);
    end

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!bus.issue_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check(tag, 32'(bus.issue_valid), 32'd1);
    endtask

    task automatic accept_one(input logic [15:0] pc);
        exp_t e;
        e.pc  = pc;
        e.ins = model_instr(pc);
        exp_q.push_back(e);
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        int k;
        exp_t e;
        for (int i = 0; i < 65536; i++) mem[i] = 8'((i * 37 + 11) & 255);
        mem[0] = 8'hF1;
        mem[1] = 8'h23;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'h0000);
        check("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        check("rst_instr", 32'(bus.instr), 32'h0000);
        check("rst_opcode", 32'(bus.opCode), 32'h0);
        check("rst_issue_pc", 32'(bus.issue_pc), 32'h0000);

        // First fetch after release
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_req", 32'(bus.mem_req), 32'd1);
        check("first_addr", 32'(bus.mem_addr), 32'h0000);
        @(posedge clk); #1;
        check("lo_addr", 32'(bus.mem_addr), 32'h0001);
        check("lo_req", 32'(bus.mem_req), 32'd1);
        @(posedge clk); #1;
        check("iss_valid", 32'(bus.issue_valid), 32'd1);
        check("iss_instr", 32'(bus.instr), 32'hF123);
        check("iss_opcode", 32'(bus.opCode), 32'hF);
        check("iss_pc", 32'(bus.issue_pc), 32'h0000);
        check("iss_no_req", 32'(bus.mem_req), 32'd0);

        // Backpressure: everything held for 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(bus.issue_valid), 32'd1);
            check("hold_instr", 32'(bus.instr), 32'hF123);
            check("hold_pc", 32'(bus.issue_pc), 32'h0000);
            check("hold_no_req", 32'(bus.mem_req), 32'd0);
        end
        accept_one(16'h0000);
        check("resume_req", 32'(bus.mem_req), 32'd1);
        check("resume_addr", 32'(bus.mem_addr), 32'h0002);

        // Throughput: three issues in nine cycles
        n0 = n_issued;
        for (int p = 2; p <= 6; p += 2) begin
            e.pc  = 16'(p);
            e.ins = model_instr(16'(p));
            exp_q.push_back(e);
        end
        ready = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        ready = 1'b0;
        check("tput_count", 32'(n_issued - n0), 32'd3);
        check("tput_sb_empty", 32'(exp_q.size()), 32'd0);

        // Redirect in FETCH_LO with slow memory
        ack_delay = 3;
        k = 0;
        while (bus.mem_addr != 16'h0009 && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        check("slow_reach_lo", 32'(bus.mem_addr), 32'h0009);
        n0 = n_issued;
        rv = 1'b1;
        rpc = 16'h0041;
        @(posedge clk); #1;
        rv = 1'b0;
        k = 0;
        while (bus.mem_addr == 16'h0009 && k < 10) begin
            check("pend_req_held", 32'(bus.mem_req), 32'd1);
            check("pend_no_issue", 32'(bus.issue_valid), 32'd0);
            @(posedge clk); #1;
            k++;
        end
        check("redir_addr", 32'(bus.mem_addr), 32'h0040);
        check("redir_req", 32'(bus.mem_req), 32'd1);
        check("redir_no_issue", 32'(n_issued - n0), 32'd0);
        ack_delay = 0;
        wait_valid("redir_valid");
        accept_one(16'h0040);

        // Redirect together with acceptance in ISSUE
        wait_valid("rr_valid");
        n0 = n_issued;
        e.pc  = 16'h0042;
        e.ins = model_instr(16'h0042);
        exp_q.push_back(e);
        ready = 1'b1;
        rv = 1'b1;
        rpc = 16'h0100;
        @(posedge clk); #1;
        ready = 1'b0;
        rv = 1'b0;
        check("rr_one_issue", 32'(n_issued - n0), 32'd1);
        check("rr_addr", 32'(bus.mem_addr), 32'h0100);
        check("rr_req", 32'(bus.mem_req), 32'd1);
        check("rr_valid_drop", 32'(bus.issue_valid), 32'd0);
        wait_valid("rr_valid2");
        accept_one(16'h0100);

        // Redirect in the same cycle as the mem_ack
        rv = 1'b1;
        rpc = 16'h0200;
        @(posedge clk); #1;
        rv = 1'b0;
        check("sameack_addr", 32'(bus.mem_addr), 32'h0200);
        check("sameack_req", 32'(bus.mem_req), 32'd1);
        wait_valid("sameack_valid");
        accept_one(16'h0200);

        // Reset pulse during FETCH_LO
        @(posedge clk); #1;
        check("prerst_lo_addr", 32'(bus.mem_addr), 32'h0203);
        rst_n = 1'b0;
        #1;
        check("arst_req", 32'(bus.mem_req), 32'd0);
        check("arst_valid", 32'(bus.issue_valid), 32'd0);
        check("arst_addr", 32'(bus.mem_addr), 32'h0000);
        check("arst_instr", 32'(bus.instr), 32'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("restart_req", 32'(bus.mem_req), 32'd1);
        check("restart_addr", 32'(bus.mem_addr), 32'h0000);
        wait_valid("restart_valid");
        accept_one(16'h0000);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // PC wrap on the second instance
        check("wrap_log_len", 32'(log2.size() >= 4), 32'd1);
        if (log2.size() >= 4) begin
            check("wrap_a0", 32'(log2[0]), 32'hFFFE);
            check("wrap_a1", 32'(log2[1]), 32'hFFFF);
            check("wrap_a2", 32'(log2[2]), 32'h0000);
            check("wrap_a3", 32'(log2[3]), 32'h0001);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Front end of the datapath. Fetches 16-bit instructions as two bytes from a byte-wide instruction memory port.
- Presents the 4-bit opCode and the full instruction to the control decoder and datapath through a valid/ready issue handshake.
- Accepts PC redirects from branch/jump resolution.
- Is the producer side of the opCode interface the control decoder consumes.

Parameters:
- PC_W, 16, width of program counter and memory address.
- RESET_PC, 0, PC value loaded on reset; bit 0 is ignored.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mem_req  output  1  byte read request to instruction memory.
- mem_addr  output  PC_W  byte address; stable while mem_req=1.
- mem_ack  input  1  read complete; mem_rdata valid this cycle; ignored when mem_req=0.
- mem_rdata  input  8  read byte.
- issue_valid  output  1  instruction available to decoder.
- issue_ready  input  1  decoder/datapath accepts instruction.
- opCode  output  4  instr[15:12].
- instr  output  16  full instruction word.
- issue_pc  output  PC_W  address of the issued instruction.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  PC_W  target address; bit 0 forced to 0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- All outputs are registered.
- Reset values:
  - state=FETCH_HI, pc=RESET_PC with bit0 cleared.
  - mem_req=0, mem_addr=pc.
  - issue_valid=0, opCode=0, instr=0, issue_pc=0.
  - redir_pend=0, redir_tgt=0.
- Byte order: big-endian. High byte at pc, low byte at pc+1.
- States:
  - FETCH_HI: mem_req=1, mem_addr=pc. On mem_ack: latch instr[15:8]=mem_rdata, go to FETCH_LO with mem_addr=pc+1 and mem_req staying 1.
  - FETCH_LO: on mem_ack: latch instr[7:0], drop mem_req, set issue_valid=1, issue_pc=pc, opCode=instr[15:12], go to ISSUE.
  - ISSUE: instr, opCode and issue_pc are held stable while issue_valid=1 and issue_ready=0. On issue_valid&issue_ready: pc<=pc+2, issue_valid<=0, state<=FETCH_HI, mem_req<=1.
- mem_req is never withdrawn before mem_ack; a request always completes.
- Timing: first mem_req=1 on the first rising edge after rst_n deasserts. With zero-wait memory and issue_ready=1, one instruction issues every 3 cycles.
- Redirects:
  - In ISSUE: applied immediately. pc<=redirect_pc, issue_valid<=0, go to FETCH_HI. If issue_ready is also 1 that cycle, the instruction counts as issued, but pc takes redirect_pc, not pc+2.
  - In FETCH_HI/FETCH_LO: redirect_pc is latched into redir_tgt and redir_pend<=1. The outstanding byte completes. On that mem_ack the byte is discarded, pc<=redir_tgt, redir_pend<=0, state<=FETCH_HI, and mem_req stays 1 with mem_addr=redir_tgt.
  - A redirect arriving in the same cycle as that mem_ack takes effect directly from redirect_pc.
  - Multiple redirects while one is pending: the newest wins.
- Arithmetic: pc+1 and pc+2 wrap modulo 2^PC_W. pc=0xFFFE fetches 0xFFFE, 0xFFFF, then next pc=0x0000.
- An asserted rst_n mid-fetch or mid-issue immediately returns all state to reset values. Any in-flight memory response is ignored because mem_req=0.

Test Plan:
- Reset release, zero-wait memory holding 0xF1 at 0x0000 and 0x23 at 0x0001, issue_ready=1 -> mem_addr 0x0000 then 0x0001; issue_valid=1 with instr=0xF123, opCode=0xF, issue_pc=0x0000; next mem_addr=0x0002.
- issue_ready held 0 for 5 cycles during ISSUE -> issue_valid, instr and issue_pc unchanged for all 5 cycles; no mem_req; fetch resumes at 0x0002 after acceptance.
- redirect_valid=1 with redirect_pc=0x0041 in FETCH_LO while mem_ack is delayed 3 cycles -> mem_req stays 1 until the ack; no issue; next mem_addr=0x0040.
- redirect_valid and issue_ready together in ISSUE, redirect_pc=0x0100 -> exactly one instruction issued; next mem_addr=0x0100.
- RESET_PC=0xFFFE, zero-wait memory -> fetch addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- rst_n pulsed low during FETCH_LO -> mem_req=0 and issue_valid=0 asynchronously; fetch restarts at RESET_PC.
